prog_loader: RTL and testbench

Writer side of the CPU's program-memory read interface: receives a nibble stream over a valid/ready handshake, writes it into a 16x4 program store, and verifies an XOR checksum.
Exposes the instruction-pair read port the CPU fetch path uses: opcode at address A, operand at A+1.
Holds the CPU (cpu_hold) until a load completes with a good checksum.

---
 rtl/prog_loader.sv | 109 ++++++++++
 tb/tb_prog_loader.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// Program-store loader: accepts a COUNT/DATA/CHECK nibble frame, fills a 16-word
// store, verifies the XOR checksum and releases the CPU only on a good load.
module prog_loader #(
  parameter int DW = 4,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data1,
  output logic [DW-1:0] rd_data2,
  output logic          cpu_hold,
  output logic          done,
  output logic          err,
  output logic [AW:0]   words_loaded
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    DATA,
    CHECK,
    LOADED,
    FAILED
  } state_t;

  state_t        state;
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] acc;
  logic [AW-1:0] addr;
  logic [AW-1:0] last_addr;
  logic [AW-1:0] rd_addr_next;
  logic          xfer;

  assign xfer = in_valid && in_ready;

  // Memory writes share the FSM block so a mid-frame reset clears both together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      acc          <= '0;
      addr         <= '0;
      last_addr    <= '0;
      words_loaded <= '0;
      in_ready     <= 1'b0;
      cpu_hold     <= 1'b1;
      done         <= 1'b0;
      err          <= 1'b0;
    end else begin
      case (state)
        IDLE, LOADED, FAILED: begin
          if (start) begin
            state        <= LEN;
            acc          <= '0;
            addr         <= '0;
            words_loaded <= '0;
            in_ready     <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
          end
        end
        LEN: begin
          if (xfer) begin
            last_addr <= in_data[AW-1:0];
            acc       <= in_data;
            state     <= DATA;
          end
        end
        DATA: begin
          if (xfer) begin
            mem[addr]    <= in_data;
            acc          <= acc ^ in_data;
            addr         <= addr + 1'b1;
            words_loaded <= words_loaded + 1'b1;
            if (addr == last_addr) state <= CHECK;
          end
        end
        CHECK: begin
          if (xfer) begin
            in_ready <= 1'b0;
            if (in_data == acc) begin
              state    <= LOADED;
              done     <= 1'b1;
              cpu_hold <= 1'b0;
            end else begin
              state <= FAILED;
              err   <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Operand word sits at the next address, wrapping from the top of the store to 0.
  assign rd_addr_next = rd_addr + 1'b1;
  assign rd_data1     = mem[rd_addr];
  assign rd_data2     = mem[rd_addr_next];

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: directed and random frames compared
// against a frame-level reference model of the program store.
module tb_prog_loader;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       in_valid;
  logic [3:0] in_data;
  logic       in_ready;
  logic [3:0] rd_addr;
  logic [3:0] rd_data1;
  logic [3:0] rd_data2;
  logic       cpu_hold;
  logic       done;
  logic       err;
  logic [4:0] words_loaded;

  int checks = 0;
  int errors = 0;

  logic [3:0] frame [$];
  logic [3:0] model_mem [16];
  logic       exp_done;
  logic       exp_err;
  logic [4:0] exp_words;

  prog_loader #(.DW(4), .AW(4)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .rd_addr      (rd_addr),
    .rd_data1     (rd_data1),
    .rd_data2     (rd_data2),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .err          (err),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: observed timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %0h required %0h", tag, observed, expected);
    end
  endtask

  // Reference model: whole frame in, expected store contents and flags out.
  task automatic modelFrame();
    int         n;
    logic [3:0] sum;
    n   = int'(frame[0]);
    sum = frame[0];
    for (int i = 0; i <= n; i++) begin
      model_mem[i] = frame[i+1];
      sum          = sum ^ frame[i+1];
    end
    exp_done  = (frame[n+2] == sum);
    exp_err   = !exp_done;
    exp_words = 5'(n + 1);
  endtask

  task automatic modelReset();
    for (int i = 0; i < 16; i++) model_mem[i] = 4'h0;
    exp_done  = 1'b0;
    exp_err   = 1'b0;
    exp_words = 5'd0;
  endtask

  task automatic pulseStart();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic sendSymbol(input logic [3:0] d, input int gap);
    int wait_cycles;
    in_valid = 1'b0;
    repeat (gap) @(negedge clk);
    in_valid    = 1'b1;
    in_data     = d;
    wait_cycles = 0;
    while (!in_ready && wait_cycles < 20) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (!in_ready) begin
      checkOutput("ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic applyStimulus(input bit do_start, input int min_gap, input int max_gap, input int start_at);
    if (do_start) pulseStart();
    for (int i = 0; i < frame.size(); i++) begin
      if (i == start_at) pulseStart();
      sendSymbol(frame[i], $urandom_range(max_gap, min_gap));
    end
    modelFrame();
  endtask

  task automatic checkResult(input string tag);
    logic [3:0] nxt;
    checkOutput({tag, "_done"},     32'(done),         32'(exp_done));
    checkOutput({tag, "_err"},      32'(err),          32'(exp_err));
    checkOutput({tag, "_hold"},     32'(cpu_hold),     32'(!exp_done));
    checkOutput({tag, "_ready"},    32'(in_ready),     32'd0);
    checkOutput({tag, "_words"},    32'(words_loaded), 32'(exp_words));
    for (int a = 0; a < 16; a++) begin
      rd_addr = 4'(a);
      nxt     = 4'(a + 1);
      #1;
      checkOutput($sformatf("%s_rd1_%0d", tag, a), 32'(rd_data1), 32'(model_mem[a]));
      checkOutput($sformatf("%s_rd2_%0d", tag, a), 32'(rd_data2), 32'(model_mem[nxt]));
    end
    @(negedge clk);
  endtask

  task automatic buildCase1();
    frame = {4'd3, 4'd1, 4'd2, 4'd3, 4'd4, 4'd7};
  endtask

  initial begin
    logic [3:0] sum;
    int         n;

    reset    = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    rd_addr  = 4'h0;
    modelReset();
    repeat (2) @(negedge clk);
    checkResult("reset");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] case 1: basic load");
    buildCase1();
    applyStimulus(1'b1, 0, 0, -1);
    checkResult("case1");

    $display("[TB] case 2: full 16-word load");
    frame = {4'd15};
    for (int i = 0; i < 16; i++) frame.push_back(4'(i));
    frame.push_back(4'hF);
    applyStimulus(1'b1, 0, 0, -1);
    checkResult("case2");

    $display("[TB] case 3: bad checksum");
    frame = {4'd1, 4'd5, 4'd6, 4'd0};
    applyStimulus(1'b1, 0, 0, -1);
    checkResult("case3");

    $display("[TB] case 4: stalls and ignored start");
    buildCase1();
    applyStimulus(1'b1, 3, 3, 2);
    checkResult("case4");

    $display("[TB] case 5: reset mid-frame");
    buildCase1();
    pulseStart();
    for (int i = 0; i < 3; i++) sendSymbol(frame[i], 0);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutput("case5_ready_async", 32'(in_ready), 32'd0);
    checkOutput("case5_hold_async",  32'(cpu_hold), 32'd1);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkResult("case5_rst");
    buildCase1();
    applyStimulus(1'b1, 0, 1, -1);
    checkResult("case5_reload");

    $display("[TB] case 6: restart after done");
    pulseStart();
    checkOutput("case6_hold", 32'(cpu_hold), 32'd1);
    checkOutput("case6_done", 32'(done),     32'd0);
    frame = {4'd0, 4'd9, 4'd9};
    applyStimulus(1'b0, 0, 0, -1);
    checkResult("case6");

    $display("[TB] random frames");
    for (int k = 0; k < 10; k++) begin
      n     = $urandom_range(15, 0);
      frame = {4'(n)};
      sum   = 4'(n);
      for (int i = 0; i <= n; i++) begin
        frame.push_back(4'($urandom_range(15, 0)));
        sum = sum ^ frame[i+1];
      end
      if ($urandom_range(3, 0) == 0) sum = sum ^ 4'($urandom_range(15, 1));
      frame.push_back(sum);
      applyStimulus(1'b1, 0, 2, ($urandom_range(1, 0) == 1) ? 2 : -1);
      checkResult($sformatf("rand%0d", k));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
